// File: rtl/bouncing_box_gen_if.sv
// rtl/bouncing_box_gen_if.sv - pixel-coordinate / colour link between the VGA sync stage and the box generator
//
// Purpose: carries the sync stage's current pixel coordinates and pause
// control into the box generator, and the generated colour and frame tick
// back out.
//
// Signals:
//   pause       sync side -> generator, level, freezes box motion while high
//   hc          sync side -> generator, 11-bit current horizontal coordinate
//   vc          sync side -> generator, 11-bit current vertical coordinate
//   rgb         generator -> sync side, CD-bit pixel colour
//   frame_tick  generator -> sync side, one-clk pulse per detected frame boundary
//
// Modports:
//   master  the sync stage (drives coordinates, samples colour)
//   slave   the box generator

interface bouncing_box_gen_if #(
  parameter int CD = 12
);
  logic          pause;
  logic [10:0]   hc;
  logic [10:0]   vc;
  logic [CD-1:0] rgb;
  logic          frame_tick;

  modport master (
    output pause,
    output hc,
    output vc,
    input  rgb,
    input  frame_tick
  );

  modport slave (
    input  pause,
    input  hc,
    input  vc,
    output rgb,
    output frame_tick
  );
endinterface

// File: rtl/bouncing_box_gen.sv
// rtl/bouncing_box_gen.sv - bouncing square pixel source feeding the VGA sync stage
//
// Purpose: draws a solid BOX x BOX square over a background with a
// one-pixel border. The square moves STEP pixels per axis once per frame
// and bounces off the screen edges. Colour is produced through a 2-stage
// pipeline from the incoming coordinates.
//
// Ports:
//   clk    system clock, shared with the sync stage
//   reset  asynchronous, active-high reset
//   bus    slave side of bouncing_box_gen_if
//            in : pause, hc, vc
//            out: rgb, frame_tick

module bouncing_box_gen #(
  parameter int            CD           = 12,
  parameter int            HD           = 640,
  parameter int            VD           = 480,
  parameter int            BOX          = 32,
  parameter int            STEP         = 2,
  parameter logic [CD-1:0] BOX_COLOR    = 12'hF00,
  parameter logic [CD-1:0] BORDER_COLOR = 12'hFFF,
  parameter logic [CD-1:0] BG_COLOR     = 12'h00F
) (
  input  logic               clk,
  input  logic               reset,
  bouncing_box_gen_if.slave  bus
);

  // 11-bit copies of the geometry so every compare is width-matched.
  localparam logic [10:0] C_HD     = 11'(HD);
  localparam logic [10:0] C_VD     = 11'(VD);
  localparam logic [10:0] C_HD_M1  = 11'(HD - 1);
  localparam logic [10:0] C_VD_M1  = 11'(VD - 1);
  localparam logic [10:0] C_XMAX   = 11'(HD - BOX);
  localparam logic [10:0] C_YMAX   = 11'(VD - BOX);
  localparam logic [10:0] C_STEP   = 11'(STEP);
  localparam logic [11:0] C_STEP12 = 12'(STEP);
  localparam logic [11:0] C_BOX12  = 12'(BOX);

  // ---------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------
  logic w_fb;
  logic r_fb_d;
  logic r_frame_tick;

  assign w_fb = (bus.hc == 11'd0) && (bus.vc == C_VD);

  // r_fb_d resets high so a reset released while fb is already asserted
  // does not produce a tick; the next tick waits for a fresh rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fb_d       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_fb_d       <= w_fb;
      r_frame_tick <= w_fb & ~r_fb_d;
    end
  end

  // ---------------------------------------------------------------------
  // Box position and direction (dir = 1 means increasing coordinate)
  // ---------------------------------------------------------------------
  logic [10:0] r_box_x;
  logic [10:0] r_box_y;
  logic        r_dir_x;
  logic        r_dir_y;

  logic [10:0] w_next_x;
  logic [10:0] w_next_y;
  logic        w_next_dir_x;
  logic        w_next_dir_y;

  // Forward moves clamp at the far limit; backward moves clamp at zero
  // before subtracting, so no wrapped value is ever produced.
  always_comb begin
    w_next_x     = r_box_x;
    w_next_dir_x = r_dir_x;
    if (r_dir_x) begin
      if (({1'b0, r_box_x} + C_STEP12) >= {1'b0, C_XMAX}) begin
        w_next_x     = C_XMAX;
        w_next_dir_x = 1'b0;
      end else begin
        w_next_x     = r_box_x + C_STEP;
      end
    end else begin
      if (r_box_x <= C_STEP) begin
        w_next_x     = 11'd0;
        w_next_dir_x = 1'b1;
      end else begin
        w_next_x     = r_box_x - C_STEP;
      end
    end
  end

  always_comb begin
    w_next_y     = r_box_y;
    w_next_dir_y = r_dir_y;
    if (r_dir_y) begin
      if (({1'b0, r_box_y} + C_STEP12) >= {1'b0, C_YMAX}) begin
        w_next_y     = C_YMAX;
        w_next_dir_y = 1'b0;
      end else begin
        w_next_y     = r_box_y + C_STEP;
      end
    end else begin
      if (r_box_y <= C_STEP) begin
        w_next_y     = 11'd0;
        w_next_dir_y = 1'b1;
      end else begin
        w_next_y     = r_box_y - C_STEP;
      end
    end
  end

  // The tick fires at the start of vertical blanking, so moving on the
  // clock after it never changes the box mid-picture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_box_x <= 11'd0;
      r_box_y <= 11'd0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (r_frame_tick && !bus.pause) begin
      r_box_x <= w_next_x;
      r_box_y <= w_next_y;
      r_dir_x <= w_next_dir_x;
      r_dir_y <= w_next_dir_y;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline stage 1: classify the current coordinate
  // ---------------------------------------------------------------------
  logic [11:0] w_box_x_end;
  logic [11:0] w_box_y_end;
  logic        w_vis;
  logic        w_in_box;
  logic        w_edge;

  logic        r_vis;
  logic        r_in_box;
  logic        r_edge;

  // End coordinates are 12 bits so box_x + BOX cannot wrap near the limit.
  assign w_box_x_end = {1'b0, r_box_x} + C_BOX12;
  assign w_box_y_end = {1'b0, r_box_y} + C_BOX12;

  assign w_vis    = (bus.hc < C_HD) && (bus.vc < C_VD);
  assign w_in_box = (bus.hc >= r_box_x) && ({1'b0, bus.hc} < w_box_x_end) &&
                    (bus.vc >= r_box_y) && ({1'b0, bus.vc} < w_box_y_end);
  assign w_edge   = (bus.hc == 11'd0) || (bus.hc == C_HD_M1) ||
                    (bus.vc == 11'd0) || (bus.vc == C_VD_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vis    <= 1'b0;
      r_in_box <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_vis    <= w_vis;
      r_in_box <= w_in_box;
      r_edge   <= w_edge;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline stage 2: colour select (blank > box > border > bg)
  // ---------------------------------------------------------------------
  logic [CD-1:0] w_color;
  logic [CD-1:0] r_rgb;

  always_comb begin
    w_color = BG_COLOR;
    if (!r_vis) begin
      w_color = '0;
    end else if (r_in_box) begin
      w_color = BOX_COLOR;
    end else if (r_edge) begin
      w_color = BORDER_COLOR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_color;
    end
  end

  assign bus.rgb        = r_rgb;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: doc/bouncing_box_gen.md
Name: bouncing_box_gen

Overview:
- Upstream pixel source for the VGA sync stage.
- Consumes the sync stage's current pixel coordinates (hc, vc) and produces the RGB stream that the sync stage samples as its video input.
- Draws a solid square that moves diagonally and bounces off the screen edges, over a background with a one-pixel screen border.
- Box position updates once per frame, on a detected frame boundary; pixel colour comes from a 2-stage pipeline.

Parameters:
- CD, 12, colour depth in bits per RGB sample.
- HD, 640, visible width in pixels.
- VD, 480, visible height in lines.
- BOX, 32, box side length in pixels; 1 <= BOX < min(HD, VD).
- STEP, 2, box movement per frame, in pixels per axis; 1 <= STEP < BOX.
- BOX_COLOR, 12'hF00, box colour.
- BORDER_COLOR, 12'hFFF, screen-edge border colour.
- BG_COLOR, 12'h00F, background colour.

Ports:
- clk  in  1  system clock (same clock as the sync stage).
- reset  in  1  asynchronous, active-high reset.
- pause  in  1  level; while high, box position and direction are frozen.
- hc  in  11  current horizontal pixel coordinate from the sync stage.
- vc  in  11  current vertical line coordinate from the sync stage.
- rgb  out  CD  pixel colour to the sync stage's video input.
- frame_tick  out  1  one-clk pulse at each detected frame boundary.

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-high. All state is on clk's posedge and is cleared asynchronously by reset.
- Reset values:
  - rgb = 0, frame_tick = 0.
  - box_x = 0, box_y = 0 (top-left corner of the box).
  - dir_x = +1 (right), dir_y = +1 (down).
  - Pipeline registers = 0; the edge-detect register = 1, so no tick fires on the first clock after reset.
- Coordinate hold: hc/vc advance once every 4 clks, so each coordinate value is held for several clks. Logic must not assume a single-clk coordinate.
- Frame boundary detection:
  - fb = (hc == 0 && vc == VD). fb_d is a 1-clk registered copy of fb.
  - frame_tick = fb & ~fb_d, registered, so exactly one clk high per frame regardless of how long hc/vc hold.
  - No tick while fb stays high.
- Position update (on the clk following frame_tick, when pause == 0):
  - X axis, moving right: if box_x + STEP >= HD - BOX, set box_x = HD - BOX and dir_x = left; else box_x += STEP.
  - X axis, moving left: if box_x <= STEP, set box_x = 0 and dir_x = right; else box_x -= STEP.
  - Y axis: same rules using VD and dir_y.
  - X and Y update in the same clk and independently, so a corner hit reverses both directions at once.
  - Position arithmetic is 11-bit unsigned. The comparisons above are the only underflow guards; no negative intermediate is ever stored.
  - pause == 1 at frame_tick: no update for that frame; position and direction are unchanged and frame_tick still pulses. Deasserting pause mid-frame has no effect until the next tick.
- Pixel pipeline, latency 2 clk from hc/vc to rgb:
  - Stage 1 registers:
    - vis = (hc < HD) && (vc < VD).
    - in_box = (hc >= box_x) && (hc < box_x + BOX) && (vc >= box_y) && (vc < box_y + BOX).
    - edge = (hc == 0) || (hc == HD-1) || (vc == 0) || (vc == VD-1).
  - Stage 2 registers rgb with priority: !vis gives 0; else in_box gives BOX_COLOR; else edge gives BORDER_COLOR; else BG_COLOR.
  - Stage 1 uses the current box_x/box_y. Updates occur only during vertical blanking, so no frame shows a tear.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). After release, the first frame_tick occurs at the next rising edge of fb. A reset released while fb == 1 yields no tick until the following frame.
- Out-of-range inputs (hc >= HD or vc >= VD) always give rgb = 0; the box never renders outside the visible area.

Test Plan:
- Reset with hc=0, vc=0 held 4 clks each, release -> 2 clks later rgb = 12'hF00 (box at 0,0 takes priority over border); hc=100, vc=100 -> rgb = 12'h00F; hc=639, vc=200 -> 12'hFFF; hc=700 -> 12'h000.
- Drive hc=0, vc=480 for 8 clks after being at vc=479 -> frame_tick high exactly 1 clk; next frame box at (2,2): hc=1, vc=1 -> BG_COLOR; hc=2, vc=2 -> BOX_COLOR.
- Run 304 ticks from reset -> box_x = 608 = HD-BOX, dir_x flips; tick 305 -> box_x = 606. In parallel, box_y reaches 448 at tick 224, then decrements.
- Hold pause=1 across 3 ticks -> 3 frame_tick pulses, box position unchanged; release pause -> the next tick moves the box by STEP.
- Preload a corner approach (run until box_x=608 and box_y=448 coincide, or force via STEP=1 with HD-BOX = VD-BOX configuration) -> both directions reverse on the same tick.
- Assert reset asynchronously mid-line (between clk edges) -> rgb and frame_tick = 0 immediately; box at (0,0) after release; no spurious tick while fb=1 at release.
